spi_xfer_master: RTL and testbench

//  Word-level SPI master (mode 0: CPOL=0, CPHA=0) that drives the bridge's external SPI pins from the 16 MHz system clock.

---
 rtl/spi_bridge_pkg.sv | 16 +
 rtl/spi_sclk_gen.sv | 42 ++++
 rtl/spi_xfer_master.sv | 164 ++++++++++++++++
 tb/tb_spi_xfer_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared state encoding and default sizing for the SPI bridge serial engine.
package spi_bridge_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;

    localparam int unsigned SPI_MODE       = 0;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_CLK_DIV    = 2;
    localparam int unsigned DEF_GAP_CYCLES = 4;

    // Width of a counter that must be able to hold max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period generator: toggles o_sclk every CLK_DIV enabled cycles and flags
// the edge that raises or lowers it with one-cycle strobes.
module spi_sclk_gen
    import spi_bridge_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_en,
    input  logic i_clr,
    output logic o_rise_stb,
    output logic o_fall_stb,
    output logic o_sclk
);

    localparam int unsigned CNT_W = cnt_w(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_toggle;

    assign w_toggle   = i_en && !i_clr && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_rise_stb = w_toggle && !r_sclk;
    assign o_fall_stb = w_toggle && r_sclk;
    assign o_sclk     = r_sclk;

    always_ff @(posedge CLK) begin
        if (!RST_N || i_clr) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (i_en) begin
            if (w_toggle) begin
                r_cnt  <= '0;
                r_sclk <= ~r_sclk;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_master.sv
// Word-level SPI mode-0 master: one word per tx handshake, MSB first, received word on rx_valid.
// Define SPI_LOOPBACK_EN to sample MOSI instead of MISO for bring-up self-test.
module spi_xfer_master
    import spi_bridge_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_keep_sel,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              clk_output,
    output logic              mosi_output,
    output logic              sel_output,
    input  logic              miso_input
);

    localparam int unsigned BIT_W  = cnt_w(DATA_W);
    localparam int unsigned WAIT_W = cnt_w((CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES);

    spi_state_t        r_state;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [DATA_W-1:0] r_tx_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_keep;
    logic              r_tx_ready;
    logic              r_rx_valid;
    logic              r_sel;
    logic              r_mosi;

    logic w_start;
    logic w_en;
    logic w_rise;
    logic w_fall;
    logic w_sample;
    logic w_bits_done;
    logic w_hold_last;
    logic w_rx_next;

`ifdef SPI_LOOPBACK_EN
    assign w_sample = r_mosi;
`else
    assign w_sample = miso_input;
`endif

    assign w_start     = tx_valid && r_tx_ready;
    assign w_bits_done = (r_bit_cnt == BIT_W'(DATA_W));
    assign w_en        = (r_state == SETUP) || ((r_state == SHIFT) && !w_bits_done);
    assign w_hold_last = (r_state == HOLD) && (r_wait_cnt == WAIT_W'(CLK_DIV - 1));
    // rx_valid/tx_ready are registered, so they are raised on the edge entering the last HOLD cycle.
    assign w_rx_next   = (CLK_DIV == 1) ? ((r_state == SHIFT) && w_bits_done)
                                        : ((r_state == HOLD) && (32'(r_wait_cnt) + 32'd2 == CLK_DIV));

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_en       (w_en),
        .i_clr      (w_start),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall),
        .o_sclk     (clk_output)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_keep     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_sel      <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_rx_next) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_rx_sr;
                r_tx_ready <= r_keep;
            end
            if (w_rise) begin
                r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_sample};
            end

            if (w_start) begin
                // Entered from IDLE or from the last HOLD cycle of a kept-select word.
                r_state    <= SETUP;
                r_sel      <= 1'b0;
                r_mosi     <= tx_data[DATA_W-1];
                r_tx_sr    <= tx_data;
                r_keep     <= tx_keep_sel;
                r_tx_ready <= 1'b0;
                r_bit_cnt  <= '0;
                r_wait_cnt <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_tx_ready <= 1'b1;
                    end
                    SETUP: begin
                        if (w_rise) begin
                            r_state   <= SHIFT;
                            r_bit_cnt <= '0;
                        end
                    end
                    SHIFT: begin
                        if (w_fall) begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            if (r_bit_cnt != BIT_W'(DATA_W - 1)) begin
                                r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                                r_mosi  <= r_tx_sr[DATA_W-2];
                            end
                        end
                        if (w_bits_done) begin
                            r_state    <= HOLD;
                            r_wait_cnt <= '0;
                        end
                    end
                    HOLD: begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        if (w_hold_last) begin
                            r_state    <= GAP;
                            r_sel      <= 1'b1;
                            r_tx_ready <= 1'b0;
                            r_wait_cnt <= '0;
                        end
                    end
                    GAP: begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        if (r_wait_cnt == WAIT_W'(GAP_CYCLES - 1)) begin
                            r_state    <= IDLE;
                            r_tx_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = r_tx_ready;
    assign rx_valid    = r_rx_valid;
    assign rx_data     = r_rx_data;
    assign busy        = (r_state != IDLE);
    assign mosi_output = r_mosi;
    assign sel_output  = r_sel;

endmodule

// File: tb/tb_spi_xfer_master.sv
// Directed self-checking bench for spi_xfer_master with a mode-0 SPI slave model and rx scoreboard.
module tb_spi_xfer_master;

    localparam int unsigned DW     = 8;
    localparam int unsigned CD     = 2;
    localparam int unsigned GAPC   = 4;
    localparam int          RX_LAT = 1 + 2 * CD * DW + CD;

    logic          CLK;
    logic          RST_N;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_keep_sel;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          busy;
    logic          clk_output;
    logic          mosi_output;
    logic          sel_output;
    logic          miso_input;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    spi_xfer_master #(
        .DATA_W     (DW),
        .CLK_DIV    (CD),
        .GAP_CYCLES (GAPC)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_keep_sel (tx_keep_sel),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .busy        (busy),
        .clk_output  (clk_output),
        .mosi_output (mosi_output),
        .sel_output  (sel_output),
        .miso_input  (miso_input)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Mode-0 slave: presents MSB while selected, advances on each SCLK fall.
    logic [7:0] slave_word = 8'h00;
    logic [2:0] idx = 3'd0;
    always @(negedge clk_output or posedge sel_output) begin
        if (sel_output) idx <= 3'd0;
        else            idx <= idx + 3'd1;
    end
    assign miso_input = slave_word[3'd7 - idx];

    int         rise_cnt  = 0;
    logic [7:0] mosi_cap  = 8'h00;
    time        last_rise = 0;
    time        period    = 0;
    always @(posedge clk_output) begin
        mosi_cap <= {mosi_cap[6:0], mosi_output};
        rise_cnt <= rise_cnt + 1;
        if (last_rise != 0) period <= $time - last_rise;
        last_rise <= $time;
    end

    int sel_run  = 0;
    int last_run = 0;
    int bad_clk  = 0;
    always @(negedge CLK) begin
        if (!sel_output) begin
            sel_run <= sel_run + 1;
        end else begin
            if (sel_run != 0) last_run <= sel_run;
            sel_run <= 0;
        end
        if (clk_output && sel_output) bad_clk <= bad_clk + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the rx_valid negedge (keep=1) or first IDLE negedge.
    task automatic do_word(input logic [7:0] d, input logic keep, input logic hold,
                           input logic [7:0] slv);
        int         acc;
        int         r0;
        int         rdy;
        int         rx_c;
        int         g;
        int         w;
        logic       got;
        logic [7:0] e;
        slave_word  = slv;
        tx_data     = d;
        tx_keep_sel = keep;
        tx_valid    = 1'b1;
`ifdef SPI_LOOPBACK_EN
        exp_q.push_back(d);
`else
        exp_q.push_back(slv);
`endif
        w = 0;
        while (!tx_ready && w < 100) begin
            @(negedge CLK);
            w++;
        end
        chk("accept", tx_ready, 1'b1);
        acc = cyc + 1;
        r0  = rise_cnt;
        @(negedge CLK);
        if (!hold) tx_valid = 1'b0;
        chk("sel_low_cycle1", sel_output, 1'b0);
        chk("mosi_msb_cycle1", mosi_output, d[7]);
        got  = 1'b0;
        rdy  = 0;
        rx_c = 0;
        for (int i = 0; i < 200; i++) begin
            if (rx_valid) begin
                got  = 1'b1;
                rx_c = cyc - acc + 1;
                break;
            end
            if (tx_ready) rdy++;
            @(negedge CLK);
        end
        chk("rx_valid_seen", got, 1'b1);
        chk("rx_valid_cycle", rx_c, RX_LAT);
        chk("ready_in_transfer", rdy, 0);
        chk("ready_last_hold", tx_ready, keep);
        chk("sclk_rises", rise_cnt - r0, 8);
        chk("mosi_bits", mosi_cap, d);
        chk("sb_nonempty", exp_q.size(), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("rx_data", rx_data, e);
        if (hold) tx_valid = 1'b0;
        if (!keep) begin
            g = 0;
            @(negedge CLK);
            while (busy && g < 20) begin
                if (!sel_output || clk_output) g = 100;
                g++;
                @(negedge CLK);
            end
            chk("gap_cycles", g, GAPC);
            chk("ready_idle", tx_ready, 1'b1);
        end
    endtask

    int acc5;
    int rxp;

    initial begin
        RST_N       = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        tx_keep_sel = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_sel", sel_output, 1'b1);
        chk("rst_sclk", clk_output, 1'b0);
        chk("rst_mosi", mosi_output, 1'b0);
        chk("rst_ready", tx_ready, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", tx_ready, 1'b1);

        // Single word: bit order, latency, SCLK period and select width.
        do_word(8'hA5, 1'b0, 1'b0, 8'h3C);
        chk("sclk_period", 32'(period), 32'd40);
        chk("sel_low_single", last_run, 35);

        // Two-word frame with select held across the boundary.
        do_word(8'h01, 1'b1, 1'b0, 8'h96);
        do_word(8'hFF, 1'b0, 1'b0, 8'h5A);
        chk("sel_low_frame", last_run, 70);

        // tx_valid held high through the whole transfer.
        do_word(8'h3C, 1'b0, 1'b1, 8'hC3);

        // Reset in the middle of a transfer.
        slave_word  = 8'h11;
        tx_data     = 8'h77;
        tx_keep_sel = 1'b0;
        tx_valid    = 1'b1;
        acc5        = cyc + 1;
        @(negedge CLK);
        tx_valid = 1'b0;
        while (cyc - acc5 + 1 < 10) @(negedge CLK);
        chk("abort_sel_before", sel_output, 1'b0);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("abort_sel", sel_output, 1'b1);
        chk("abort_sclk", clk_output, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", tx_ready, 1'b0);
        chk("abort_rx_data", rx_data, 8'h00);
        RST_N = 1'b1;
        rxp   = 0;
        for (int i = 0; i < 60; i++) begin
            if (rx_valid) rxp++;
            @(negedge CLK);
        end
        chk("abort_no_rx_valid", rxp, 0);
        do_word(8'hC5, 1'b0, 1'b0, 8'h6B);

`ifdef SPI_LOOPBACK_EN
        do_word(8'h5A, 1'b0, 1'b0, 8'h00);
        do_word(8'h81, 1'b0, 1'b0, 8'h00);
`endif

        chk("sclk_low_when_deselected", bad_clk, 0);
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
